mem_seq_ctrl: RTL and testbench
===============================

MEM_SEQ_CTRL -- requirements
Module: mem_seq_ctrl

Interface
REQ-001 SHALL have parameter W, default 24: data width of bank words, RQ and RD.
REQ-002 SHALL have parameter NR, default 32: number of data-bank registers.
REQ-003 SHALL have parameter ADDRW, default 5: bank address width.
REQ-004 SHALL have parameter FRAC, default 12: fractional bits of the signed fixed-point format.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 cmd_valid  input  1  command offered.
REQ-009 cmd_ready  output  1  high only in IDLE.
REQ-010 cmd_op  input  2  00 DOT_Q, 01 DOT_D, 10 STORE_Q, 11 STORE_D.
REQ-011 cmd_a / cmd_b / cmd_dst  input  ADDRW each  vector A base, vector B base, store destination.
REQ-012 cmd_len  input  ADDRW+1  dot-product length, 0..NR.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 write, dira, dirb, data  output  1/ADDRW/ADDRW/W  data-bank control.
REQ-016 A, B  input  W  data-bank asynchronous read data.
REQ-017 rq_we, rq_d, rd_we, rd_d  output  1/W/1/W  accumulator-register writes.
REQ-018 RQ, RD  input  W  accumulator-register current values.

Function
REQ-019 A command SHALL be accepted on a rising edge where cmd_valid && cmd_ready; all cmd_* fields are latched at acceptance, and cmd_valid while busy SHALL be ignored.
REQ-020 States SHALL be IDLE, CLR, MAC, STORE and DONE; DOT_* goes IDLE->CLR->MAC->DONE->IDLE, and STORE_* goes IDLE->STORE->DONE->IDLE.
REQ-021 CLR lasts one cycle and writes 0 to the target accumulator (rq_we=1, rq_d=0 for DOT_Q; rd_we=1, rd_d=0 for DOT_D); when len=0, CLR goes directly to DONE.
REQ-022 MAC lasts exactly len cycles, and in cycle i SHALL drive dira=(a+i) mod NR, dirb=(b+i) mod NR, write=0, and target_we=1.
REQ-023 In MAC, target_d SHALL equal target + ((A*B)>>>FRAC), computed as a signed 2W-bit product with an arithmetic shift (floor) and a wider sum, then reduced to W bits per REQ-033/034.
REQ-024 STORE lasts one cycle with write=1, dira=dst, and data=RQ (STORE_Q) or RD (STORE_D).
REQ-025 done SHALL be 1 only in DONE, giving latency from acceptance edge to done of len+2 cycles for DOT_* and 2 cycles for STORE_*.
REQ-026 write, rq_we and rd_we SHALL be 0 outside CLR, MAC and STORE, and the non-target accumulator's we SHALL always be 0.
REQ-027 When idle, dira, dirb and data SHALL be 0.
REQ-028 Address arithmetic SHALL wrap modulo NR; the bench uses NR = 2^ADDRW. A len value greater than NR SHALL be clamped to NR.

Reset
REQ-029 Asserting rst_n low SHALL immediately force state IDLE, cmd_ready=1, and busy=done=write=rq_we=rd_we=0, with dira=dirb=data=rq_d=rd_d=0.
REQ-030 Reset mid-operation SHALL abandon the command with no done pulse; bank, RQ and RD contents are left as last written.
REQ-031 The first command SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-032 The macro MEM_SEQ_CTRL_SAT_EN SHALL select accumulator overflow behaviour.
REQ-033 With MEM_SEQ_CTRL_SAT_EN defined, the MAC result SHALL saturate to [-2^(W-1), 2^(W-1)-1].
REQ-034 With MEM_SEQ_CTRL_SAT_EN undefined, the MAC result SHALL be the low W bits (two's-complement wrap).

Verification
REQ-035 bank[0]=4096, bank[1]=8192, bank[8]=12288, bank[9]=2048; DOT_Q with a=0, b=8, len=2 -> RQ=16384 and done exactly 4 cycles after acceptance.
REQ-036 Then STORE_Q with dst=20 -> a single write=1 cycle at dira=20 with data=16384, bank[20]=16384, and done 2 cycles after acceptance.
REQ-037 bank[2]=bank[3]=0x3FFFFF; DOT_D with a=2, b=3, len=1 -> RD=0x7FFFFF with SAT_EN defined, and RD=0xFFF800 without it.
REQ-038 DOT_Q with len=0 -> RQ=0, no MAC cycles, done 2 cycles after acceptance.
REQ-039 DOT_Q with a=31, b=30, len=3 -> read pairs (31,30), (0,31), (1,0) in order.
REQ-040 rst_n pulsed low in MAC cycle 2 of len=5 -> outputs zero during the reset pulse, no done, RD unchanged, and a new command accepted right after release.

Source files
------------

// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl: command-driven sequencer for a data bank and two accumulators.
// A command runs either a fixed-point dot product into RQ or RD, or a store
// of RQ or RD back into the bank.
// Build option: define MEM_SEQ_CTRL_SAT_EN to saturate MAC results instead of
// wrapping them to W bits.
module mem_seq_ctrl #(
  parameter int W     = 24,
  parameter int NR    = 32,
  parameter int ADDRW = 5,
  parameter int FRAC  = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [ADDRW-1:0] cmd_a,
  input  logic [ADDRW-1:0] cmd_b,
  input  logic [ADDRW-1:0] cmd_dst,
  input  logic [ADDRW:0]   cmd_len,
  output logic             busy,
  output logic             done,
  output logic             write,
  output logic [ADDRW-1:0] dira,
  output logic [ADDRW-1:0] dirb,
  output logic [W-1:0]     data,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  output logic             rq_we,
  output logic [W-1:0]     rq_d,
  output logic             rd_we,
  output logic [W-1:0]     rd_d,
  input  logic [W-1:0]     RQ,
  input  logic [W-1:0]     RD
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_MAC, S_STORE, S_DONE} state_t;

  localparam logic [ADDRW:0]   NR_LEN  = (ADDRW+1)'(NR);
  localparam logic [ADDRW+1:0] NR_WIDE = (ADDRW+2)'(NR);

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;      // bit1: store, bit0: target is RD
  logic [ADDRW-1:0] a_q, a_d, b_q, b_d, dst_q, dst_d;
  logic [ADDRW:0]   len_q, len_d, cnt_q, cnt_d;

  // (base + off) mod NR; base < NR and off < NR so one subtraction suffices
  function automatic logic [ADDRW-1:0] wrap_add(input logic [ADDRW-1:0] base,
                                                input logic [ADDRW:0] off);
    logic [ADDRW+1:0] s;
    s = {2'b00, base} + {1'b0, off};
    if (s >= NR_WIDE) s = s - NR_WIDE;
    return s[ADDRW-1:0];
  endfunction

  logic [W-1:0]          acc_cur;
  logic signed [2*W-1:0] prod;
  logic signed [2*W-1:0] prod_sh;
  logic signed [2*W:0]   sum;
  logic [W-1:0]          mac_res;

  // Fixed-point MAC: floor-shifted signed product added to the target accumulator
  always_comb begin
    acc_cur = op_q[0] ? RD : RQ;
    prod    = $signed(A) * $signed(B);
    prod_sh = prod >>> FRAC;
    sum     = $signed(acc_cur) + prod_sh;
  end

`ifdef MEM_SEQ_CTRL_SAT_EN
  // Clamp to the W-bit signed range when the wide sum does not fit
  always_comb begin
    if ((&sum[2*W:W-1]) || !(|sum[2*W:W-1])) mac_res = sum[W-1:0];
    else if (sum[2*W])                       mac_res = {1'b1, {(W-1){1'b0}}};
    else                                     mac_res = {1'b0, {(W-1){1'b1}}};
  end
`else
  // Two's-complement wrap: keep only the low W bits of the sum
  logic unused_sum_hi;
  assign unused_sum_hi = ^sum[2*W:W];
  assign mac_res       = sum[W-1:0];
`endif

  // State and latched command registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and bank/accumulator control outputs
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    dst_d     = dst_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    write     = 1'b0;
    dira      = '0;
    dirb      = '0;
    data      = '0;
    rq_we     = 1'b0;
    rq_d      = '0;
    rd_we     = 1'b0;
    rd_d      = '0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          op_d    = cmd_op;
          a_d     = cmd_a;
          b_d     = cmd_b;
          dst_d   = cmd_dst;
          len_d   = (cmd_len > NR_LEN) ? NR_LEN : cmd_len;
          cnt_d   = '0;
          state_d = cmd_op[1] ? S_STORE : S_CLR;
        end
      end
      S_CLR: begin
        if (op_q[0]) rd_we = 1'b1;
        else         rq_we = 1'b1;
        cnt_d   = '0;
        state_d = (len_q == '0) ? S_DONE : S_MAC;
      end
      S_MAC: begin
        dira = wrap_add(a_q, cnt_q);
        dirb = wrap_add(b_q, cnt_q);
        if (op_q[0]) begin
          rd_we = 1'b1;
          rd_d  = mac_res;
        end else begin
          rq_we = 1'b1;
          rq_d  = mac_res;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == len_q - 1'b1) state_d = S_DONE;
      end
      S_STORE: begin
        write   = 1'b1;
        dira    = dst_q;
        data    = op_q[0] ? RD : RQ;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Directed bench for mem_seq_ctrl with behavioural bank and accumulator models.
module tb_mem_seq_ctrl;
  localparam int W = 24, NR = 32, ADDRW = 5, FRAC = 12;

`ifdef MEM_SEQ_CTRL_SAT_EN
  localparam logic [63:0] EXP_BIG = 64'h7FFFFF;
`else
  localparam logic [63:0] EXP_BIG = 64'hFFF800;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [ADDRW-1:0] cmd_a, cmd_b, cmd_dst;
  logic [ADDRW:0]   cmd_len;
  logic             busy, done, write;
  logic [ADDRW-1:0] dira, dirb;
  logic [W-1:0]     data, A, B;
  logic             rq_we, rd_we;
  logic [W-1:0]     rq_d, rd_d, RQ, RD;

  logic [W-1:0]     bank [0:NR-1] = '{default: '0};
  logic [W-1:0]     rq_m = '0;
  logic [W-1:0]     rd_m = '0;
  logic             tb_we = 1'b0;
  logic [ADDRW-1:0] tb_addr = '0;
  logic [W-1:0]     tb_data = '0;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int edges;

  always #5 clk = ~clk;

  assign A  = bank[dira];
  assign B  = bank[dirb];
  assign RQ = rq_m;
  assign RD = rd_m;

  always @(posedge clk) begin
    if (write)      bank[dira]    <= data;
    else if (tb_we) bank[tb_addr] <= tb_data;
    if (rq_we) rq_m <= rq_d;
    if (rd_we) rd_m <= rd_d;
  end

  mem_seq_ctrl #(.W(W), .NR(NR), .ADDRW(ADDRW), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_dst(cmd_dst),
    .cmd_len(cmd_len), .busy(busy), .done(done), .write(write),
    .dira(dira), .dirb(dirb), .data(data), .A(A), .B(B),
    .rq_we(rq_we), .rq_d(rq_d), .rd_we(rd_we), .rd_d(rd_d), .RQ(RQ), .RD(RD)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic preload(input int addr, input logic [W-1:0] val);
    tb_addr = ADDRW'(addr);
    tb_data = val;
    tb_we   = 1'b1;
    tick();
    tb_we   = 1'b0;
  endtask

  // Present a command at a negedge; returns at the negedge after the acceptance edge
  task automatic issue(input logic [1:0] op, input int a, input int b, input int dst, input int len);
    cmd_op    = op;
    cmd_a     = ADDRW'(a);
    cmd_b     = ADDRW'(b);
    cmd_dst   = ADDRW'(dst);
    cmd_len   = (ADDRW+1)'(len);
    cmd_valid = 1'b1;
    $display("cmd op=%0d a=%0d b=%0d dst=%0d len=%0d", op, a, b, dst, len);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0;
    cmd_a = '0; cmd_b = '0; cmd_dst = '0; cmd_len = '0;
    @(negedge clk);
    // Reset state
    check("rst_ctrl", 64'({cmd_ready, busy, done, write, rq_we, rd_we}), 64'b100000);
    check("rst_addr", 64'({dira, dirb}), 64'd0);
    check("rst_data", 64'({data, rq_d, rd_d}), 64'd0);
    preload(0, 24'd4096);
    preload(1, 24'd8192);
    preload(8, 24'd12288);
    preload(9, 24'd2048);

    // DOT_Q a=0 b=8 len=2, presented on the release cycle
    rst_n = 1'b1;
    issue(2'b00, 0, 8, 0, 2);
    check("dq_clr_ctrl", 64'({cmd_ready, busy, done, rq_we, rd_we}), 64'b01010);
    check("dq_clr_d", 64'(rq_d), 64'd0);
    cmd_op = 2'b11; cmd_dst = 5'd5; cmd_a = 5'd7; cmd_valid = 1'b1;   // ignored while busy
    tick();
    check("dq_mac0_addr", 64'({dira, dirb}), 64'({5'd0, 5'd8}));
    check("dq_mac0_d", 64'(rq_d), 64'd12288);
    check("dq_mac0_we", 64'({write, rq_we, rd_we}), 64'b010);
    tick();
    check("dq_mac1_addr", 64'({dira, dirb}), 64'({5'd1, 5'd9}));
    check("dq_mac1_d", 64'(rq_d), 64'd16384);
    tick();
    check("dq_done", 64'({done, busy, rq_we}), 64'b110);
    cmd_valid = 1'b0;
    tick();
    check("dq_idle", 64'({done, cmd_ready, busy}), 64'b010);
    check("dq_rq", 64'(rq_m), 64'd16384);
    check("dq_no_store", 64'(bank[5]), 64'd0);

    // STORE_Q dst=20
    issue(2'b10, 0, 0, 20, 0);
    check("sq_ctrl", 64'({write, rq_we, rd_we, busy}), 64'b1001);
    check("sq_addr", 64'(dira), 64'd20);
    check("sq_data", 64'(data), 64'd16384);
    tick();
    check("sq_done", 64'({done, write}), 64'b10);
    tick();
    check("sq_bank", 64'(bank[20]), 64'd16384);
    check("sq_idle", 64'({done, cmd_ready}), 64'b01);

    // DOT_D saturation / wrap case
    preload(2, 24'h3FFFFF);
    preload(3, 24'h3FFFFF);
    issue(2'b01, 2, 3, 0, 1);
    check("dd_clr", 64'({rq_we, rd_we}), 64'b01);
    tick();
    check("dd_mac_addr", 64'({dira, dirb}), 64'({5'd2, 5'd3}));
    check("dd_mac_d", 64'(rd_d), EXP_BIG);
    tick();
    check("dd_done", 64'(done), 64'd1);
    tick();
    check("dd_rd", 64'(rd_m), EXP_BIG);
    check("dd_rq_kept", 64'(rq_m), 64'd16384);

    // DOT_Q len=0
    issue(2'b00, 0, 8, 0, 0);
    check("z_clr", 64'({rq_we, rq_d}), 64'({1'b1, 24'd0}));
    tick();
    check("z_done", 64'({done, rq_we, rd_we}), 64'b100);
    tick();
    check("z_rq", 64'(rq_m), 64'd0);

    // DOT_Q a=31 b=30 len=3 wraps addresses
    issue(2'b00, 31, 30, 0, 3);
    tick();
    check("w_pair0", 64'({dira, dirb}), 64'({5'd31, 5'd30}));
    tick();
    check("w_pair1", 64'({dira, dirb}), 64'({5'd0, 5'd31}));
    tick();
    check("w_pair2", 64'({dira, dirb}), 64'({5'd1, 5'd0}));
    check("w_d2", 64'(rq_d), 64'd8192);
    tick();
    check("w_done", 64'(done), 64'd1);
    tick();
    check("w_rq", 64'(rq_m), 64'd8192);

    // len=40 clamps to NR=32: done on edge 34 counting the acceptance edge
    issue(2'b01, 0, 0, 0, 40);
    edges = 1;
    while (!done && edges < 60) begin
      tick();
      edges++;
    end
    check("clamp_lat", 64'(edges), 64'd34);
    tick();

    // Reset during MAC cycle 2 of a len=5 DOT_D
    issue(2'b01, 0, 8, 0, 5);
    tick();
    tick();
    tick();
    check("rm_mac2_addr", 64'({dira, dirb}), 64'({5'd2, 5'd10}));
    rst_n = 1'b0;
    #1;
    check("rm_ctrl", 64'({cmd_ready, busy, done, write, rq_we, rd_we}), 64'b100000);
    check("rm_bus", 64'({dira, dirb, data}), 64'd0);
    check("rm_accd", 64'({rq_d, rd_d}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("rm_no_done", 64'(done), 64'd0);
    check("rm_rd", 64'(rd_m), 64'd16384);
    rst_n = 1'b1;
    issue(2'b11, 0, 0, 21, 0);
    check("rm_store", 64'({write, dira, data}), 64'({1'b1, 5'd21, 24'd16384}));
    tick();
    check("rm_done", 64'(done), 64'd1);
    tick();
    check("rm_bank", 64'(bank[21]), 64'd16384);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
